// File: rtl/fb_pkg.sv
// fb_pkg: shared types and widths for the framebuffer frame sequencer.
//   PIX_W    - pixel index width (up to 2^19 pixels per buffer)
//   ADDR_W   - framebuffer address width: {buffer select, pixel index}
//   COLOR_W  - palette index width
//   fb_state_t - sequencer FSM states
//   fb_addr() - builds a framebuffer address from a buffer select and a pixel index
package fb_pkg;

  localparam int unsigned PIX_W   = 19;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned COLOR_W = 4;

  typedef logic [PIX_W-1:0]   pix_addr_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDraw,
    StWaitSwap
  } fb_state_t;

  function automatic fb_addr_t fb_addr(input logic buf_sel, input pix_addr_t pix);
    return {buf_sel, pix};
  endfunction

endpackage

// File: rtl/fb_clear_counter.sv
// fb_clear_counter: pixel index counter used by the clear engine.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   start_i       - reload the counter with 0 (wins over step_i)
//   step_i        - advance to the next pixel
//   cnt_o         - current pixel index
//   last_o        - current index is the final pixel (NumPix-1)
module fb_clear_counter
  import fb_pkg::*;
#(
  parameter int unsigned NumPix = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             step_i,
  output logic [PIX_W-1:0] cnt_o,
  output logic             last_o
);

  pix_addr_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = pix_addr_t'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == pix_addr_t'(NumPix - 1));

endmodule

// File: rtl/fb_frame_sequencer.sv
// fb_frame_sequencer: per-frame controller that owns the framebuffer write port.
// Each frame: clear the back buffer, let the sprite drawer run (its writes are forwarded
// with one cycle of latency), then wait for vertical blank to swap buffers.
// Build option: FB_DOUBLE_BUFFER_EN - when defined, draw_buf_o toggles on each swap and a
// finished frame waits in StWaitSwap; when undefined, draw_buf_o stays 0 and a finished
// frame returns to StIdle.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   vsync_start_i      - one-cycle pulse at start of vertical blank
//   sprite_start_o     - one-cycle pulse in the first draw cycle
//   sprite_done_i      - sprite drawer finished
//   sprite_write_i, sprite_w_addr_i, sprite_wdata_i - sprite write request
//   fb_write_o, fb_w_addr_o, fb_wdata_o - registered framebuffer write port
//   draw_buf_o         - buffer being drawn
//   frame_busy_o       - high while clearing or drawing
//   overrun_cnt_o      - saturating count of vsync pulses that arrived mid-frame
module fb_frame_sequencer
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH    = 640,
  parameter int unsigned FB_HEIGHT   = 480,
  parameter color_t      CLEAR_COLOR = 4'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               vsync_start_i,
  output logic               sprite_start_o,
  input  logic               sprite_done_i,
  input  logic               sprite_write_i,
  input  logic [PIX_W-1:0]   sprite_w_addr_i,
  input  logic [COLOR_W-1:0] sprite_wdata_i,
  output logic               fb_write_o,
  output logic [ADDR_W-1:0]  fb_w_addr_o,
  output logic [COLOR_W-1:0] fb_wdata_o,
  output logic               draw_buf_o,
  output logic               frame_busy_o,
  output logic [7:0]         overrun_cnt_o
);

  // FB_WIDTH*FB_HEIGHT must not exceed 2^19 so the pixel index fits PIX_W bits.
  localparam int unsigned NumPix = FB_WIDTH * FB_HEIGHT;

  fb_state_t state_q, state_d;
  logic      fb_write_q, fb_write_d;
  fb_addr_t  fb_w_addr_q, fb_w_addr_d;
  color_t    fb_wdata_q, fb_wdata_d;
  logic      draw_buf_q, draw_buf_d;
  logic      busy_q, busy_d;
  logic      sprite_start_q, sprite_start_d;
  logic [7:0] overrun_q, overrun_d;

  logic      cnt_start, cnt_step, cnt_last;
  pix_addr_t cnt;

  fb_clear_counter #(
    .NumPix(NumPix)
  ) u_clear_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(cnt_start),
    .step_i (cnt_step),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    draw_buf_d     = draw_buf_q;
    overrun_d      = overrun_q;
    fb_write_d     = 1'b0;
    fb_w_addr_d    = '0;
    fb_wdata_d     = '0;
    sprite_start_d = 1'b0;
    cnt_start      = 1'b0;
    cnt_step       = 1'b0;

    // A vsync mid-frame never restarts or swaps; it is only counted.
    if (vsync_start_i && (state_q == StClear || state_q == StDraw) && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end

    unique case (state_q)
      StIdle, StWaitSwap: begin
        if (vsync_start_i) begin
`ifdef FB_DOUBLE_BUFFER_EN
          if (state_q == StWaitSwap) begin
            draw_buf_d = ~draw_buf_q;
          end
`endif
          // Pixel 0 is registered on the entry edge so the clear has no bubble.
          state_d     = StClear;
          cnt_start   = 1'b1;
          fb_write_d  = 1'b1;
          fb_w_addr_d = fb_addr(draw_buf_d, '0);
          fb_wdata_d  = CLEAR_COLOR;
        end
      end
      StClear: begin
        // cnt is the pixel currently presented on the write port.
        if (cnt_last) begin
          state_d        = StDraw;
          sprite_start_d = 1'b1;
        end else begin
          cnt_step    = 1'b1;
          fb_write_d  = 1'b1;
          fb_w_addr_d = fb_addr(draw_buf_q, pix_addr_t'(cnt + 1'b1));
          fb_wdata_d  = CLEAR_COLOR;
        end
      end
      StDraw: begin
        if (sprite_write_i) begin
          fb_write_d  = 1'b1;
          fb_w_addr_d = fb_addr(draw_buf_q, sprite_w_addr_i);
          fb_wdata_d  = sprite_wdata_i;
        end
        if (sprite_done_i) begin
`ifdef FB_DOUBLE_BUFFER_EN
          state_d = StWaitSwap;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StClear) || (state_d == StDraw);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      fb_write_q     <= 1'b0;
      fb_w_addr_q    <= '0;
      fb_wdata_q     <= '0;
      draw_buf_q     <= 1'b0;
      busy_q         <= 1'b0;
      sprite_start_q <= 1'b0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      fb_write_q     <= fb_write_d;
      fb_w_addr_q    <= fb_w_addr_d;
      fb_wdata_q     <= fb_wdata_d;
      draw_buf_q     <= draw_buf_d;
      busy_q         <= busy_d;
      sprite_start_q <= sprite_start_d;
      overrun_q      <= overrun_d;
    end
  end

  assign fb_write_o     = fb_write_q;
  assign fb_w_addr_o    = fb_w_addr_q;
  assign fb_wdata_o     = fb_wdata_q;
  assign draw_buf_o     = draw_buf_q;
  assign frame_busy_o   = busy_q;
  assign sprite_start_o = sprite_start_q;
  assign overrun_cnt_o  = overrun_q;

endmodule
